boss_attack_sched: RTL and testbench

Frame-tick-driven scheduler for the boss: sequences chase, wind-up, attack and cooldown phases, and picks melee or ranged attacks from boss/player distance. It gates the boss movement logic and drives the attack renderer and hit logic, switching to shorter cooldowns once boss HP falls below the enrage threshold. It sits beside the boss movement, HP and render units inside the boss top level.

---
 rtl/boss_attack_sched.sv | 156 +++++++++++++++
 tb/tb_boss_attack_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/boss_attack_sched.sv
// Boss attack scheduler: frame-paced CHASE -> WINDUP -> ATTACK loop with
// melee/ranged selection by distance and a sticky enrage that shortens cooldown.
module boss_attack_sched #(
  parameter int WINDUP_FRAMES   = 30,
  parameter int ATTACK_FRAMES   = 20,
  parameter int COOLDOWN_NORMAL = 90,
  parameter int COOLDOWN_ENRAGE = 45,
  parameter int ENRAGE_HP       = 50,
  parameter int MELEE_RANGE     = 150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  game_active,
  input  logic        game_start,
  input  logic        frame_tick,
  input  logic [6:0]  boss_hp,
  input  logic        boss_alive,
  input  logic [11:0] boss_x,
  input  logic [11:0] char_x,
  output logic        move_en,
  output logic        windup,
  output logic        attack_start,
  output logic        attack_active,
  output logic        attack_type,
  output logic        enraged,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHASE  = 3'd1,
    ST_WINDUP = 3'd2,
    ST_ATTACK = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  localparam logic [8:0]  CD_NORMAL = 9'(COOLDOWN_NORMAL);
  localparam logic [8:0]  CD_ENRAGE = 9'(COOLDOWN_ENRAGE);
  localparam logic [8:0]  WU_LEN    = 9'(WINDUP_FRAMES);
  localparam logic [8:0]  AT_LEN    = 9'(ATTACK_FRAMES);
  localparam logic [12:0] MELEE_LIM = 13'(MELEE_RANGE);
  localparam logic [6:0]  ENR_LIM   = 7'(ENRAGE_HP);

  state_t      st_q, st_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        enr_q, enr_d;
  logic        atype_q, atype_d;
  logic        move_en_d, windup_d, attack_start_d, attack_active_d, enraged_d;

  logic        playing_s, hp_low_s, dead_s, restart_s, ranged_s, active_s, phase_done_s;
  logic [12:0] diff_s, absd_s;
  logic [8:0]  cnt_inc_s, limit_s;

  assign playing_s = (game_active == 2'd1);
  assign hp_low_s  = (boss_hp < ENR_LIM);
  assign dead_s    = (!boss_alive) || (boss_hp == 7'd0);
  assign restart_s = game_start && ((st_q != ST_IDLE) || playing_s);
  assign diff_s    = {1'b0, boss_x} - {1'b0, char_x};
  assign absd_s    = diff_s[12] ? (13'd0 - diff_s) : diff_s;
  assign ranged_s  = (absd_s >= MELEE_LIM);
  assign cnt_inc_s = {1'b0, cnt_q} + 9'd1;

  // Frame budget of the current phase; >= lets a mid-CHASE enrage fire on the next tick.
  always_comb begin
    case (st_q)
      ST_CHASE:  limit_s = enr_q ? CD_ENRAGE : CD_NORMAL;
      ST_WINDUP: limit_s = WU_LEN;
      ST_ATTACK: limit_s = AT_LEN;
      default:   limit_s = 9'd511;
    endcase
  end

  assign phase_done_s = frame_tick && (cnt_inc_s >= limit_s);

  // Next state, counter, latched attack type and enrage flag by event priority.
  always_comb begin
    st_d    = st_q;
    atype_d = atype_q;
    enr_d   = enr_q | hp_low_s;
    if (restart_s) begin
      st_d    = ST_CHASE;
      enr_d   = hp_low_s;
      atype_d = 1'b0;
    end else if ((st_q != ST_IDLE) && dead_s) begin
      st_d = ST_DEAD;
    end else if ((st_q != ST_IDLE) && !playing_s) begin
      st_d = ST_IDLE;
    end else if (phase_done_s) begin
      case (st_q)
        ST_CHASE: begin
          st_d    = ST_WINDUP;
          atype_d = ranged_s;
        end
        ST_WINDUP: st_d = ST_ATTACK;
        ST_ATTACK: st_d = ST_CHASE;
        default:   st_d = st_q;
      endcase
    end else begin
      st_d = st_q;
    end

    if (restart_s || (st_d != st_q)) begin
      cnt_d = 8'd0;
    end else if (frame_tick && (cnt_q != 8'd255)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if ((st_d == ST_IDLE) || (st_d == ST_DEAD)) begin
      atype_d = 1'b0;
    end else begin
      atype_d = atype_d;
    end
  end

  // Output values for the state being entered, so outputs register alongside it.
  always_comb begin
    active_s        = (st_d == ST_CHASE) || (st_d == ST_WINDUP) || (st_d == ST_ATTACK);
    move_en_d       = (st_d == ST_CHASE) || ((st_d == ST_ATTACK) && atype_d);
    windup_d        = (st_d == ST_WINDUP);
    attack_active_d = (st_d == ST_ATTACK);
    attack_start_d  = (st_d == ST_ATTACK) && (st_q != ST_ATTACK);
    enraged_d       = enr_d && active_s;
  end

  // State, counter, flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= ST_IDLE;
      cnt_q         <= 8'd0;
      enr_q         <= 1'b0;
      atype_q       <= 1'b0;
      move_en       <= 1'b0;
      windup        <= 1'b0;
      attack_start  <= 1'b0;
      attack_active <= 1'b0;
      attack_type   <= 1'b0;
      enraged       <= 1'b0;
      state         <= 3'd0;
    end else begin
      st_q          <= st_d;
      cnt_q         <= cnt_d;
      enr_q         <= enr_d;
      atype_q       <= atype_d;
      move_en       <= move_en_d;
      windup        <= windup_d;
      attack_start  <= attack_start_d;
      attack_active <= attack_active_d;
      attack_type   <= atype_d;
      enraged       <= enraged_d;
      state         <= st_d;
    end
  end

endmodule

// File: tb/tb_boss_attack_sched.sv
// Bench for boss_attack_sched: directed scenarios plus random play, every cycle
// compared against a phase-table reference model.
module tb_boss_attack_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  game_active;
  logic        game_start, frame_tick, boss_alive;
  logic [6:0]  boss_hp;
  logic [11:0] boss_x, char_x;
  logic        move_en, windup, attack_start, attack_active, attack_type, enraged;
  logic [2:0]  state;

  int n_chk  = 0;
  int n_pass = 0;
  int as_cnt = 0;

  // Reference model: phase index (0 idle,1 chase,2 windup,3 attack,4 dead)
  int m_st, m_prev, m_frames;
  bit m_enr, m_type;

  boss_attack_sched dut (
    .clk(clk), .rst_n(rst_n), .game_active(game_active), .game_start(game_start),
    .frame_tick(frame_tick), .boss_hp(boss_hp), .boss_alive(boss_alive),
    .boss_x(boss_x), .char_x(char_x), .move_en(move_en), .windup(windup),
    .attack_start(attack_start), .attack_active(attack_active),
    .attack_type(attack_type), .enraged(enraged), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
  endtask

  function automatic int phase_len(input int ph, input bit enr);
    case (ph)
      1:       return enr ? 45 : 90;
      2:       return 30;
      3:       return 20;
      default: return 1000;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_prev = 0; m_frames = 0; m_enr = 0; m_type = 0;
  endtask

  task automatic model_update();
    int nxt, d;
    bit hp_low;
    hp_low = (boss_hp < 7'd50);
    m_prev = m_st;
    nxt    = m_st;
    if (game_start && (m_st != 0 || game_active == 2'd1)) begin
      nxt = 1; m_frames = 0; m_enr = hp_low; m_type = 0;
    end else begin
      if (m_st != 0 && (!boss_alive || boss_hp == 7'd0)) nxt = 4;
      else if (m_st != 0 && game_active != 2'd1) nxt = 0;
      else if (frame_tick && m_st >= 1 && m_st <= 3 && m_frames + 1 >= phase_len(m_st, m_enr)) begin
        nxt = (m_st == 3) ? 1 : m_st + 1;
        if (m_st == 1) begin
          d = int'(boss_x) - int'(char_x);
          if (d < 0) d = -d;
          m_type = (d >= 150);
        end
      end
      if (nxt != m_st) m_frames = 0;
      else if (frame_tick && m_frames < 255) m_frames++;
      m_enr = m_enr | hp_low;
      if (nxt == 0 || nxt == 4) m_type = 0;
    end
    m_st = nxt;
  endtask

  function automatic logic [8:0] model_vec();
    bit act;
    act = (m_st >= 1 && m_st <= 3);
    return {3'(m_st), m_enr && act, m_type && act, m_st == 3, m_st == 3 && m_prev != 3,
            m_st == 2, m_st == 1 || (m_st == 3 && m_type)};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {state, enraged, attack_type, attack_active, attack_start, windup, move_en};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    if (attack_start) as_cnt++;
    chk("cycle", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic tick_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc(); cyc();
    end
  endtask

  task automatic pulse_start();
    game_start = 1'b1; cyc(); game_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; game_active = 2'd0; game_start = 1'b0; frame_tick = 1'b0;
    boss_hp = 7'd100; boss_alive = 1'b1; boss_x = 12'd400; char_x = 12'd300;
    model_reset();
    #12;
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Full non-enraged cycle, melee then ranged
    game_active = 2'd1;
    pulse_start();
    chk("start_chase", 32'(state), 32'd1);
    as_cnt = 0;
    tick_frames(125);
    chk("melee_type", 32'(attack_type), 32'd0);
    chk("melee_move", 32'(move_en), 32'd0);
    tick_frames(15);
    chk("back_chase", 32'(state), 32'd1);
    chk("one_attack_start", 32'(as_cnt), 32'd1);
    char_x = 12'd700;
    tick_frames(125);
    chk("ranged_type", 32'(attack_type), 32'd1);
    chk("ranged_move", 32'(move_en), 32'd1);
    tick_frames(15);

    // Enrage mid-CHASE, then death during ATTACK
    boss_hp = 7'd60; char_x = 12'd300;
    pulse_start();
    tick_frames(50);
    boss_hp = 7'd49;
    cyc();
    chk("enraged_set", 32'(enraged), 32'd1);
    tick_frames(1);
    chk("enrage_windup", 32'(state), 32'd2);
    tick_frames(50);
    tick_frames(45);
    chk("enraged_cooldown", 32'(state), 32'd2);
    tick_frames(40);
    boss_alive = 1'b0;
    cyc();
    chk("dead_state", 32'(state), 32'd4);
    chk("dead_attack_off", 32'(attack_active), 32'd0);
    boss_alive = 1'b1; boss_hp = 7'd100;
    tick_frames(3);
    pulse_start();
    chk("restart_chase", 32'(state), 32'd1);
    chk("restart_unenraged", 32'(enraged), 32'd0);

    // Leaving play during WINDUP
    tick_frames(90);
    game_active = 2'd2;
    cyc();
    chk("idle_state", 32'(dut_vec()), 32'd0);
    tick_frames(5);
    chk("idle_stays", 32'(state), 32'd0);
    game_active = 2'd1;
    pulse_start();
    chk("idle_restart", 32'(state), 32'd1);

    // Asynchronous reset during ATTACK
    tick_frames(125);
    chk("pre_reset_attack", 32'(state), 32'd3);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(dut_vec()), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    cyc();
    chk("post_reset_idle", 32'(state), 32'd0);

    // Random play against the model
    for (int i = 0; i < 9000; i++) begin
      frame_tick  = ($urandom_range(0, 1) == 0);
      game_start  = ($urandom_range(0, 1499) == 0) || ((m_st == 0 || m_st == 4) && $urandom_range(0, 19) == 0);
      game_active = ($urandom_range(0, 1499) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      boss_alive  = ($urandom_range(0, 2999) != 0);
      if ($urandom_range(0, 199) == 0) boss_hp = 7'($urandom_range(0, 100));
      if (frame_tick) begin
        boss_x = 12'($urandom);
        char_x = ($urandom_range(0, 1) == 0) ? boss_x + 12'($urandom_range(0, 300)) : 12'($urandom);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
